// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   arb_state_e : access sequencer states
//   OWN_I/OWN_D : owner encoding of the access in flight
//   UBHW_WORD   : funct3 width code for a full 32-bit word
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [2:0] UBHW_WORD = 3'b010;

endpackage

// File: rtl/mem_arb_streak.sv
// Saturating counter of consecutive data grants made while a fetch was waiting.
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   i_inc      : count one more data grant (saturates at LIM)
//   i_clr      : restart the streak (wins over i_inc)
//   o_at_lim   : streak has reached LIM, fetch must win next
//   o_streak   : current streak value
module mem_arb_streak #(
  parameter int unsigned LIM = 4,
  parameter int unsigned W   = $clog2(LIM + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic         o_at_lim,
  output logic [W-1:0] o_streak
);

  logic [W-1:0] r_streak;
  logic         w_at_lim;

  assign w_at_lim = (r_streak == W'(LIM));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (i_clr) begin
      r_streak <= '0;
    end else if (i_inc && !w_at_lim) begin
      r_streak <= r_streak + W'(1);
    end
  end

  assign o_at_lim = w_at_lim;
  assign o_streak = r_streak;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between an instruction fetch port and a data
// port, one access at a time. Data wins by default; after STARVE_LIM
// consecutive data grants with a fetch pending, the fetch wins.
// Ports:
//   clk, rst                        : clock, synchronous active-low reset
//   i_req/i_addr/i_abort            : fetch request, address, squash
//   i_rdata/i_ack                   : fetched word, one-cycle completion
//   d_req/d_we/d_addr/d_wdata/d_ubhw: data request
//   d_rdata/d_ack                   : load data, one-cycle completion
//   m_en/m_we/m_addr/m_wdata/m_ubhw : memory strobe and command
//   m_rdata                         : memory read data (MEM_LAT after m_en)
//   busy                            : access in flight
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_abort,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [2:0]  d_ubhw,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [2:0]  m_ubhw,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  localparam int unsigned STREAK_W = $clog2(STARVE_LIM + 1);
  // WAIT spans MEM_LAT cycles so the capture edge ends cycle ISSUE+MEM_LAT.
  localparam logic [2:0]  LAT_LAST = 3'(MEM_LAT - 1);

  arb_state_e          r_state;
  arb_state_e          w_state_next;
  logic                r_owner;
  logic                r_we;
  logic [31:0]         r_addr;
  logic [31:0]         r_wdata;
  logic [2:0]          r_ubhw;
  logic                r_drop;
  logic [2:0]          r_lat_cnt;
  logic [31:0]         r_i_rdata;
  logic [31:0]         r_d_rdata;

  logic                w_fetch_ok;
  logic                w_grant_d;
  logic                w_grant_i;
  logic                w_grant;
  logic                w_lat_done;
  logic                w_abort_hit;
  logic                w_drop_now;
  logic                w_at_lim;
  logic                w_streak_inc;
  logic                w_streak_clr;
  logic [STREAK_W-1:0] w_streak;

  // An abort in IDLE also blocks the fetch grant that cycle.
  assign w_fetch_ok = i_req & ~i_abort;
  assign w_grant_d  = d_req & ~(w_fetch_ok & w_at_lim);
  assign w_grant_i  = w_fetch_ok & ~w_grant_d;
  assign w_grant    = (r_state == StIdle) & (w_grant_d | w_grant_i);

  assign w_lat_done  = (r_state == StWait) && (r_lat_cnt == LAT_LAST);
  assign w_abort_hit = i_abort && (r_owner == OWN_I) &&
                       ((r_state == StIssue) || (r_state == StWait));
  // An abort in the final WAIT cycle must still suppress the capture.
  assign w_drop_now  = r_drop | w_abort_hit;

  assign w_streak_inc = w_grant & w_grant_d & i_req;
  assign w_streak_clr = w_grant & (w_grant_i | (w_grant_d & ~i_req));

  mem_arb_streak #(
    .LIM (STARVE_LIM),
    .W   (STREAK_W)
  ) u_streak (
    .clk      (clk),
    .rst      (rst),
    .i_inc    (w_streak_inc),
    .i_clr    (w_streak_clr),
    .o_at_lim (w_at_lim),
    .o_streak (w_streak)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_grant_d || w_grant_i) w_state_next = StIssue;
      StIssue: w_state_next = StWait;
      StWait:  if (w_lat_done) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Request latch, latency counter, drop flag and read-data capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner   <= OWN_I;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_ubhw    <= '0;
      r_drop    <= 1'b0;
      r_lat_cnt <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_grant_d ? OWN_D : OWN_I;
        r_addr  <= w_grant_d ? d_addr : i_addr;
        r_we    <= w_grant_d & d_we;
        r_wdata <= w_grant_d ? d_wdata : '0;
        r_ubhw  <= w_grant_d ? d_ubhw : UBHW_WORD;
        r_drop  <= 1'b0;
      end else if (w_abort_hit) begin
        r_drop <= 1'b1;
      end

      if (r_state == StIssue) begin
        r_lat_cnt <= '0;
      end else if (r_state == StWait) begin
        r_lat_cnt <= r_lat_cnt + 3'd1;
      end

      if (w_lat_done) begin
        if (r_owner == OWN_I) begin
          if (!w_drop_now) r_i_rdata <= m_rdata;
        end else if (!r_we) begin
          r_d_rdata <= m_rdata;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    i_ack   = 1'b0;
    d_ack   = 1'b0;
    busy    = 1'b0;
    m_addr  = r_addr;
    m_wdata = r_wdata;
    m_ubhw  = r_ubhw;
    i_rdata = r_i_rdata;
    d_rdata = r_d_rdata;
    unique case (r_state)
      StIdle: ;
      StIssue: begin
        m_en = 1'b1;
        m_we = r_we;
        busy = 1'b1;
      end
      StWait: busy = 1'b1;
      StDone: begin
        busy  = 1'b1;
        i_ack = (r_owner == OWN_I) & ~r_drop;
        d_ack = (r_owner == OWN_D);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2, STARVE_LIM=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_abort;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_ubhw;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [2:0]  m_ubhw;
  logic [31:0] m_rdata;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(
    .MEM_LAT    (2),
    .STARVE_LIM (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_abort (i_abort),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ubhw  (d_ubhw),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .m_en    (m_en),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ubhw  (m_ubhw),
    .m_rdata (m_rdata),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int   pulses;
    logic acks;

    rst = 1'b0; i_req = 1'b0; i_addr = '0; i_abort = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_ubhw = '0; m_rdata = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_m_en", m_en, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst = 1'b1;
    step();

    // Load 0x40: m_en cycle 1, data in cycle 3, ack cycle 4
    d_req = 1'b1; d_addr = 32'h40; d_ubhw = 3'b010; d_we = 1'b0;
    step();
    chk("ld_m_en_c1", m_en, 1);
    chk("ld_m_addr", m_addr, 32'h40);
    chk("ld_m_we", m_we, 0);
    chk("ld_busy_c1", busy, 1);
    step();
    chk("ld_m_en_c2", m_en, 0);
    step();
    m_rdata = 32'hDEADBEEF;
    chk("ld_d_ack_c3", d_ack, 0);
    step();
    chk("ld_d_ack_c4", d_ack, 1);
    chk("ld_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("ld_i_ack_c4", i_ack, 0);
    d_req = 1'b0; m_rdata = '0;
    step();
    chk("ld_d_ack_c5", d_ack, 0);
    chk("ld_busy_c5", busy, 0);

    // Store: m_we only in ISSUE, d_rdata untouched
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234; d_ubhw = 3'b001;
    step();
    chk("st_m_en", m_en, 1);
    chk("st_m_we_c1", m_we, 1);
    chk("st_m_addr", m_addr, 32'h80);
    chk("st_m_wdata", m_wdata, 32'h1234);
    chk("st_m_ubhw", m_ubhw, 3'b001);
    step();
    chk("st_m_we_c2", m_we, 0);
    step();
    m_rdata = 32'hCAFEF00D;
    step();
    chk("st_d_ack_c4", d_ack, 1);
    chk("st_d_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0; d_we = 1'b0; m_rdata = '0;
    step();

    // Simultaneous requests: data first, fetch issued cycle 6, acked cycle 9
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_addr = 32'h44; d_ubhw = 3'b010;
    step();
    chk("both_c1_addr", m_addr, 32'h44);
    step();
    step();
    m_rdata = 32'h11111111;
    step();
    chk("both_d_ack_c4", d_ack, 1);
    d_req = 1'b0;
    step();
    chk("both_busy_c5", busy, 0);
    chk("both_i_ack_c5", i_ack, 0);
    step();
    chk("both_m_en_c6", m_en, 1);
    chk("both_m_addr_c6", m_addr, 32'h200);
    chk("both_m_ubhw_c6", m_ubhw, 3'b010);
    chk("both_m_we_c6", m_we, 0);
    step();
    step();
    m_rdata = 32'h22222222;
    step();
    chk("both_i_ack_c9", i_ack, 1);
    chk("both_i_rdata", i_rdata, 32'h22222222);
    chk("both_d_rdata", d_rdata, 32'h11111111);
    i_req = 1'b0; m_rdata = '0;
    step();
    chk("both_streak", 32'(dut.w_streak), 0);

    // Fetch 0x100 aborted in cycle 2
    i_req = 1'b1; i_addr = 32'h100; pulses = 0;
    step();
    pulses += int'(m_en);
    step();
    pulses += int'(m_en);
    i_abort = 1'b1; i_req = 1'b0;
    step();
    pulses += int'(m_en);
    i_abort = 1'b0; m_rdata = 32'h33333333;
    step();
    pulses += int'(m_en);
    chk("ab_i_ack_c4", i_ack, 0);
    chk("ab_busy_c4", busy, 1);
    step();
    pulses += int'(m_en);
    chk("ab_busy_c5", busy, 0);
    chk("ab_i_ack_c5", i_ack, 0);
    chk("ab_i_rdata", i_rdata, 32'h22222222);
    chk("ab_m_en_pulses", 32'(pulses), 1);
    m_rdata = '0;

    // Abort in IDLE blocks the fetch grant for that cycle only
    i_req = 1'b1; i_addr = 32'h104; i_abort = 1'b1;
    step();
    chk("iab_m_en_c1", m_en, 0);
    chk("iab_busy_c1", busy, 0);
    i_abort = 1'b0;
    step();
    chk("iab_m_en_c2", m_en, 1);
    chk("iab_m_addr_c2", m_addr, 32'h104);
    step();
    step();
    m_rdata = 32'h44444444;
    step();
    chk("iab_i_ack_c5", i_ack, 1);
    chk("iab_i_rdata", i_rdata, 32'h44444444);
    i_req = 1'b0; m_rdata = '0;
    step();

    // Starvation: four data grants, then the fetch
    i_req = 1'b1; i_addr = 32'h400;
    d_req = 1'b1; d_addr = 32'h300; d_ubhw = 3'b010;
    for (int g = 0; g < 5; g++) begin
      step();
      chk($sformatf("stv_addr_%0d", g), m_addr, (g < 4) ? 32'h300 : 32'h400);
      step();
      step();
      m_rdata = 32'h5000 + 32'(g);
      step();
      if (g < 4) begin
        chk($sformatf("stv_d_ack_%0d", g), d_ack, 1);
      end else begin
        chk("stv_i_ack", i_ack, 1);
        chk("stv_i_rdata", i_rdata, 32'h5004);
        i_req = 1'b0; d_req = 1'b0;
      end
      step();
    end
    chk("stv_streak", 32'(dut.w_streak), 0);
    chk("stv_busy", busy, 0);
    m_rdata = '0;

    // Reset during WAIT discards the access
    d_req = 1'b1; d_addr = 32'h48;
    step();
    step();
    rst = 1'b0;
    step();
    chk("mr_busy", busy, 0);
    chk("mr_m_en", m_en, 0);
    chk("mr_m_addr", m_addr, 0);
    chk("mr_d_rdata", d_rdata, 0);
    chk("mr_i_rdata", i_rdata, 0);
    rst = 1'b1; d_req = 1'b0;
    acks = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      acks = acks | d_ack | i_ack;
    end
    chk("mr_no_ack", acks, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
